fwd_hazard_ctrl: RTL and testbench

- Control end of the EX-stage operand muxes: generates the 2-bit select codes consumed by the 3-input 32-bit operand muxes (A and B) in the EX stage of the 5-stage MIPS pipeline.
- Detects load-use hazards and requests a one-cycle stall.
- Keeps its own shadow pipeline of destination-register info (EX/MEM/WB) and a saturating stall counter for performance stats.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 20 ++
 rtl/fwd_hazard_ctrl_select.sv | 29 ++
 rtl/fwd_hazard_ctrl.sv | 82 ++++++++
 tb/tb_fwd_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared select codes and shadow-entry type for forwarding control
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Shadow entries store register indices zero-extended to this width; REG_W must not exceed it.
  localparam int DEST_W = 8;
  localparam logic [DEST_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic              wr;
    logic              ld;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{dest: REG_ZERO, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_hazard_ctrl_select.sv
// rtl/fwd_hazard_ctrl_select.sv - forward-select decision for one EX source operand
module fwd_select
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             src_used_i,
  input  shadow_t          ex_i,
  input  shadow_t          mem_i,
  output logic [1:0]       sel_o
);

  logic [DEST_W-1:0] src;
  assign src = DEST_W'(src_i);

  // The entry in ex reaches MEM alongside this reader; a load there has no ALU result to forward.
  always_comb begin
    sel_o = FWD_RF;
    if (src_used_i && (src != REG_ZERO)) begin
      if (ex_i.wr && !ex_i.ld && (ex_i.dest == src)) begin
        sel_o = FWD_MEM;
      end else if (mem_i.wr && (mem_i.dest == src)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects, load-use stall and stall counter
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  shadow_t ex_q, ex_d, mem_q, wb_q;
  logic [1:0] sel_a_d, sel_b_d;
  logic [DEST_W-1:0] rs_w, rt_w;
  logic hold_sel;

  assign rs_w = DEST_W'(id_rs);
  assign rt_w = DEST_W'(id_rt);

  assign stall = id_valid & ~flush & ex_q.ld & ex_q.wr & (ex_q.dest != REG_ZERO) &
                 ((ex_q.dest == rs_w) | (id_uses_rt & (ex_q.dest == rt_w)));

  assign hold_sel = stall | flush | ~id_valid;

  always_comb begin
    ex_d = SHADOW_BUBBLE;
    if (!(stall || flush)) begin
      ex_d = '{dest: DEST_W'(id_dest),
               wr:   id_valid & id_reg_write,
               ld:   id_valid & id_mem_read};
    end
  end

  fwd_select #(.REG_W(REG_W)) u_sel_a (
    .src_i      (id_rs),
    .src_used_i (1'b1),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_a_d)
  );

  fwd_select #(.REG_W(REG_W)) u_sel_b (
    .src_i      (id_rt),
    .src_used_i (id_uses_rt),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_b_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= SHADOW_BUBBLE;
      mem_q       <= SHADOW_BUBBLE;
      wb_q        <= SHADOW_BUBBLE;
      fwd_a_sel   <= FWD_RF;
      fwd_b_sel   <= FWD_RF;
      stall_count <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= hold_sel ? FWD_RF : sel_a_d;
      fwd_b_sel <= hold_sel ? FWD_RF : sel_b_d;
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed bench with instruction-history model for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel4, fwd_b_sel4;
  logic       stall, stall4;
  logic [31:0] stall_count;
  logic [3:0]  stall_count4;

  fwd_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel4),
    .fwd_b_sel(fwd_b_sel4), .stall(stall4), .stall_count(stall_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the last two instructions that entered EX, newest first.
  typedef struct {
    int dest;
    bit wr;
    bit ld;
  } prod_t;

  prod_t hist[$];
  int     exp_a, exp_b;
  longint exp_cnt;

  function automatic bit m_stall();
    prod_t p;
    if (!id_valid || flush) return 1'b0;
    p = hist[0];
    return p.ld && p.wr && (p.dest != 0) &&
           ((p.dest == int'(id_rs)) || (id_uses_rt && (p.dest == int'(id_rt))));
  endfunction

  // Distance 1 producer sits in MEM when the reader is in EX (code 2), distance 2 in WB (code 1).
  function automatic int m_sel(input int src, input bit used);
    if (!used || src == 0) return 0;
    if (hist[0].wr && hist[0].dest == src && !hist[0].ld) return 2;
    if (hist[1].wr && hist[1].dest == src) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    prod_t np;
    bit s;
    if (rst) begin
      hist = '{'{0, 1'b0, 1'b0}, '{0, 1'b0, 1'b0}};
      exp_a = 0;
      exp_b = 0;
      exp_cnt = 0;
    end else begin
      s = m_stall();
      if (s || flush || !id_valid) begin
        exp_a = 0;
        exp_b = 0;
      end else begin
        exp_a = m_sel(int'(id_rs), 1'b1);
        exp_b = m_sel(int'(id_rt), id_uses_rt);
      end
      if (s) exp_cnt++;
      if (s || flush) np = '{0, 1'b0, 1'b0};
      else np = '{int'(id_dest), id_valid && id_reg_write, id_valid && id_mem_read};
      hist.push_front(np);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, m_stall());
      chk("fwd_a_sel", fwd_a_sel, exp_a);
      chk("fwd_b_sel", fwd_b_sel, exp_b);
      chk("stall_count", stall_count, exp_cnt);
      chk("stall4", stall4, m_stall());
      chk("stall_count4", stall_count4, (exp_cnt > 15) ? 15 : exp_cnt);
    end
  end

  task automatic drive(input bit v, input int rs, input int rt, input bit urt, input int dest,
                       input bit rw, input bit mr, input bit fl, input bit r);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt; id_dest = 5'(dest);
    id_reg_write = rw; id_mem_read = mr; flush = fl; rst = r;
    @(negedge clk);
  endtask

  task automatic alu(input int d, input int s, input int t, input bit fl, input bit r);
    drive(1'b1, s, t, 1'b1, d, 1'b1, 1'b0, fl, r);
  endtask

  task automatic lw(input int d, input int base);
    drive(1'b1, base, d, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    hist = '{'{0, 1'b0, 1'b0}, '{0, 1'b0, 1'b0}};
    exp_a = 0; exp_b = 0; exp_cnt = 0;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;

    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    nop();
    chk("reset_a", fwd_a_sel, 0);
    chk("reset_b", fwd_b_sel, 0);
    chk("reset_stall", stall, 0);
    chk("reset_cnt", stall_count, 0);

    alu(3, 1, 2, 1'b0, 1'b0);
    alu(4, 3, 5, 1'b0, 1'b0);
    chk("b2b_stall", stall, 0);
    nop();
    chk("b2b_a", fwd_a_sel, 2);
    chk("b2b_b", fwd_b_sel, 0);

    alu(3, 1, 2, 1'b0, 1'b0);
    nop();
    alu(6, 5, 3, 1'b0, 1'b0);
    nop();
    chk("dist2_b", fwd_b_sel, 1);
    chk("dist2_a", fwd_a_sel, 0);

    lw(3, 1);
    alu(3, 1, 2, 1'b0, 1'b0);
    alu(7, 3, 3, 1'b0, 1'b0);
    chk("newer_stall", stall, 0);
    nop();
    chk("newer_a", fwd_a_sel, 2);
    chk("newer_b", fwd_b_sel, 2);

    lw(2, 1);
    alu(4, 2, 2, 1'b0, 1'b0);
    chk("lu_stall", stall, 1);
    chk("lu_cnt_before", stall_count, 0);
    alu(4, 2, 2, 1'b0, 1'b0);
    chk("lu_stall_once", stall, 0);
    chk("lu_cnt_after", stall_count, 1);
    chk("lu_bubble_a", fwd_a_sel, 0);
    nop();
    chk("lu_post_a", fwd_a_sel, 1);
    chk("lu_post_b", fwd_b_sel, 1);

    lw(0, 1);
    alu(4, 0, 1, 1'b0, 1'b0);
    chk("zero_stall", stall, 0);
    nop();
    chk("zero_a", fwd_a_sel, 0);
    chk("zero_b", fwd_b_sel, 0);
    lw(7, 1);
    drive(1'b1, 8, 7, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("imm_rt_stall", stall, 0);

    lw(9, 1);
    alu(10, 9, 9, 1'b1, 1'b0);
    chk("flush_stall", stall, 0);
    nop();
    chk("flush_a", fwd_a_sel, 0);
    chk("flush_b", fwd_b_sel, 0);
    chk("flush_cnt", stall_count, 1);

    lw(11, 1);
    alu(12, 11, 0, 1'b0, 1'b1);
    chk("rst_mid_stall", stall, 1);
    nop();
    chk("rst_mid_a", fwd_a_sel, 0);
    chk("rst_mid_b", fwd_b_sel, 0);
    chk("rst_mid_stall_after", stall, 0);
    chk("rst_mid_cnt", stall_count, 0);

    for (int i = 0; i < 20; i++) begin
      lw(2, 1);
      alu(4, 2, 2, 1'b0, 1'b0);
      alu(4, 2, 2, 1'b0, 1'b0);
    end
    chk("sat_cnt32", stall_count, 20);
    chk("sat_cnt4", stall_count4, 15);
    nop();
    chk("sat_cnt4_hold", stall_count4, 15);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
